pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four hazard sources:
- load-use hazards;
- taken branches resolved in EX;
- data-memory wait states;
- multi-cycle divides.

It sits beside the datapath and is the only block that controls pipeline-register advancement.

## Interface
Parameters:
- DIV_CYCLES, 8, total stall cycles per divide; legal range 2..255

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_num_write  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_div_start  in  1  instruction in EX is a divide
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register advances on the next edge
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads a bubble (all zeros) on the next edge; flush overrides en
- div_done  out  1  final cycle of a divide; EX advances
- state  out  2  RUN=0, DIV_BUSY=1, DIV_DONE=2
- stall_cycles  out  16  saturating count of cycles with pc_en=0

## Operation
Combinational conditions:
- mstall = mem_req & !mem_ready
- dstall = (state==RUN & ex_div_start) | state==DIV_BUSY
- lu = ex_mem_read & ex_num_write!=0 & ((id_uses_rs & id_rs==ex_num_write) | (id_uses_rt & id_rt==ex_num_write))

Outputs are decided by the first matching rule, in this priority order:
1. reset low: all en=0, all flush=0.
2. mstall: all en=0 except mem_wb_en=1; mem_wb_flush=1. All other flushes are 0. The branch or load-use action is deferred because EX is held.
3. dstall: pc_en, if_id_en, id_ex_en = 0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1.
4. ex_branch_taken: all en=1; if_id_flush=1 and id_ex_flush=1. This rule overrides lu.
5. lu: pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
6. Otherwise: all en=1, all flush=0.

Divide FSM, with an 8-bit counter cnt:
- RUN: if ex_div_start & !mstall, load cnt=DIV_CYCLES-2 and go to DIV_BUSY. An ex_div_start arriving under mstall is not started; it is retried once mstall clears.
- DIV_BUSY: if cnt==0 go to DIV_DONE, else decrement cnt. Counting continues during mstall.
- DIV_DONE: div_done=1 and ex_div_start is ignored. Go to RUN when !mstall; otherwise hold in DIV_DONE.

stall_cycles increments when reset is high and pc_en=0, and saturates at 0xFFFF.

## Timing
- Reset values: state=RUN, cnt=0, div_done=0, stall_cycles=0. Reset is asynchronous and may be asserted mid-divide; the FSM returns to RUN immediately.
- Detection is zero-latency: every en/flush output is a function of the current-cycle inputs and state, and is acted on at the next clock edge.
- Load-use costs exactly 1 bubble, because the load has moved to MEM by the next cycle.
- Divide detected in cycle T:
  - cycles T..T+DIV_CYCLES-1 are stalled;
  - div_done=1 in cycle T+DIV_CYCLES, when EX advances;
  - with no mstall, the FSM is back in RUN at T+DIV_CYCLES+1.
- mstall holds for as many cycles as mem_ready stays low. The cycle in which mem_ready=1 is unstalled.
- Branch and load-use in the same cycle: only the branch action applies; no PC freeze.

## Test plan
- Load-use: ex_mem_read=1, ex_num_write=5, id_rs=5, id_uses_rs=1 → for 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1 afterwards. Repeat with ex_num_write=0 → no stall.
- Branch: ex_branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_en=1.
- Divide with DIV_CYCLES=4: ex_div_start high from T →
  - pc_en=0 for T..T+3;
  - ex_mem_flush=1 for T..T+3;
  - div_done=1 at T+4;
  - state sequence RUN, BUSY, BUSY, BUSY, DONE, RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles → all upstream en=0 and mem_wb_flush=1 for 3 cycles; normal operation on the mem_ready=1 cycle; stall_cycles=3.
- Interactions:
  - mstall raised during DIV_BUSY → the counter still reaches DIV_DONE on schedule;
  - mstall raised in DIV_DONE → state holds DIV_DONE until mem_ready=1.
- Reset low in DIV_BUSY → immediately state=RUN, cnt=0, stall_cycles=0, all en=0. After release, ex_div_start=1 restarts a full DIV_CYCLES stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Arbitrates memory wait, divide, branch and load-use hazards.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_num_write,
  input  logic        ex_branch_taken,
  input  logic        ex_div_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        div_done,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 2);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [15:0] r_stall;
  logic        w_mstall;
  logic        w_dstall;
  logic        w_lu;
  logic        w_rs_hit;
  logic        w_rt_hit;

  assign w_mstall = mem_req & ~mem_ready;
  assign w_dstall = (r_state == RUN & ex_div_start)
                  | (r_state == DIV_BUSY);
  assign w_rs_hit = id_uses_rs & (id_rs == ex_num_write);
  assign w_rt_hit = id_uses_rt & (id_rt == ex_num_write);
  assign w_lu     = ex_mem_read & (ex_num_write != 5'd0)
                  & (w_rs_hit | w_rt_hit);

  // Reset is folded in so the pipe freezes the moment it drops.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      pc_en = 1'b0;
    end else if (w_mstall) begin
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (w_dstall) begin
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_en    = 1'b1;
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_lu) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      RUN: begin
        if (ex_div_start && !w_mstall) begin
          w_next     = DIV_BUSY;
          w_cnt_next = CNT_INIT;
        end
      end
      DIV_BUSY: begin
        if (r_cnt == 8'd0) w_next = DIV_DONE;
        else w_cnt_next = r_cnt - 8'd1;
      end
      DIV_DONE: begin
        if (!w_mstall) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 8'd0;
      r_stall <= 16'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (!pc_en && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign div_done     = (r_state == DIV_DONE);
  assign state        = r_state;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (DIV_CYCLES=4).
// Expected control vectors are queued as stimulus is driven.
module tb_pipe_hazard_ctrl;

  typedef logic [21:0] stim_t;
  typedef logic [11:0] exp_t;

  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_MST  = 9'b00001_0001;
  localparam logic [8:0] C_DST  = 9'b00011_0010;
  localparam logic [8:0] C_BR   = 9'b11111_1100;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_RST  = 9'b00000_0000;

  localparam stim_t IDLE  = 22'h0;
  localparam stim_t DIVS  = 22'h4;
  localparam stim_t MWAIT = 22'h2;
  localparam stim_t MDONE = 22'h3;
  localparam stim_t DIVMW = 22'h6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_num_write;
  logic        id_uses_rs, id_uses_rt, ex_mem_read;
  logic        ex_branch_taken, ex_div_start;
  logic        mem_req, mem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush;
  logic        ex_mem_flush, mem_wb_flush;
  logic        div_done;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_stall = 16'd0;
  exp_t        q[$];

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_num_write(ex_num_write),
    .ex_branch_taken(ex_branch_taken),
    .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .div_done(div_done), .state(state),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic stim_t s(
    logic rd, logic [4:0] wn, logic [4:0] rs, logic [4:0] rt,
    logic urs, logic urt, logic br, logic dv,
    logic mq, logic mr);
    return {rd, wn, rs, rt, urs, urt, br, dv, mq, mr};
  endfunction

  function automatic exp_t e(logic [8:0] c, logic dd,
                             logic [1:0] st);
    return {c, dd, st};
  endfunction

  function automatic exp_t obs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush,
            mem_wb_flush, div_done, state};
  endfunction

  task automatic apply(stim_t v);
    {ex_mem_read, ex_num_write, id_rs, id_rt,
     id_uses_rs, id_uses_rt, ex_branch_taken,
     ex_div_start, mem_req, mem_ready} = v;
  endtask

  task automatic test_reset();
    exp_t x;
    apply(IDLE);
    q.push_back(e(C_RST, 1'b0, 2'd0));
    @(negedge clock);
    x = q.pop_front();
    checks++;
    if (obs() !== x) begin
      failures++;
      $display("FAIL reset_out got=%b exp=%b", obs(), x);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  x;
    st = '{s(1,5,5,0,1,0,0,0,0,0), IDLE,
           s(1,0,0,0,1,0,0,0,0,0),
           s(1,7,0,7,0,1,0,0,0,0),
           s(1,7,7,0,0,0,0,0,0,0),
           s(0,5,5,0,1,0,0,0,0,0), IDLE};
    ex = '{e(C_LU,0,0), e(C_NORM,0,0), e(C_NORM,0,0),
           e(C_LU,0,0), e(C_NORM,0,0), e(C_NORM,0,0),
           e(C_NORM,0,0)};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), x);
      end
      if (i == 1) begin
        checks++;
        if (stall_cycles !== exp_stall + 16'd1) begin
          failures++;
          $display("FAIL lu_one_bubble got=%0d exp=%0d",
                   stall_cycles, exp_stall + 16'd1);
        end
      end
    end
    exp_stall += 16'd2;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL lu_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_branch();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  x;
    st = '{s(1,5,5,0,1,0,1,0,0,0),
           s(0,0,0,0,0,0,1,0,0,0), IDLE};
    ex = '{e(C_BR,0,0), e(C_BR,0,0), e(C_NORM,0,0)};
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL br_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  x;
    st = '{MWAIT, MWAIT, MWAIT, MDONE,
           s(1,5,5,0,1,0,0,0,1,0),
           s(1,5,5,0,1,0,0,0,1,1), IDLE};
    ex = '{e(C_MST,0,0), e(C_MST,0,0), e(C_MST,0,0),
           e(C_NORM,0,0), e(C_MST,0,0), e(C_LU,0,0),
           e(C_NORM,0,0)};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL mem_wait[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    exp_stall += 16'd5;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL mem_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_divide();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  x;
    st = '{DIVS, DIVS, DIVS, DIVS, DIVS, IDLE};
    ex = '{e(C_DST,0,0), e(C_DST,0,1), e(C_DST,0,1),
           e(C_DST,0,1), e(C_NORM,1,2), e(C_NORM,0,0)};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL divide[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    exp_stall += 16'd4;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL div_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_div_mstall();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  x;
    st = '{DIVMW, DIVS, DIVMW, DIVMW, DIVS, DIVS, IDLE};
    ex = '{e(C_MST,0,0), e(C_DST,0,0), e(C_MST,0,1),
           e(C_MST,0,1), e(C_DST,0,1), e(C_NORM,1,2),
           e(C_NORM,0,0)};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL div_mstall[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    exp_stall += 16'd5;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL divms_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_done_mstall();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  x;
    st = '{DIVS, DIVS, DIVS, DIVS, DIVMW, DIVMW, DIVS, IDLE};
    ex = '{e(C_DST,0,0), e(C_DST,0,1), e(C_DST,0,1),
           e(C_DST,0,1), e(C_MST,1,2), e(C_MST,1,2),
           e(C_NORM,1,2), e(C_NORM,0,0)};
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL done_mstall[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    exp_stall += 16'd6;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL donems_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset_mid_div();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  x;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      apply(DIVS);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    q.push_back(e(C_RST, 1'b0, 2'd0));
    @(negedge clock);
    x = q.pop_front();
    checks++;
    if (obs() !== x) begin
      failures++;
      $display("FAIL midreset_out got=%b exp=%b", obs(), x);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL midreset_stall got=%0d exp=0", stall_cycles);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    apply(IDLE);
    exp_stall = 16'd0;
    st = '{DIVS, DIVS, DIVS, DIVS, DIVS, IDLE};
    ex = '{e(C_DST,0,0), e(C_DST,0,1), e(C_DST,0,1),
           e(C_DST,0,1), e(C_NORM,1,2), e(C_NORM,0,0)};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      apply(st[i]);
      q.push_back(ex[i]);
      @(negedge clock);
      x = q.pop_front();
      checks++;
      if (obs() !== x) begin
        failures++;
        $display("FAIL restart[%0d] got=%b exp=%b", i, obs(), x);
      end
    end
    exp_stall += 16'd4;
    checks++;
    if (stall_cycles !== exp_stall) begin
      failures++;
      $display("FAIL restart_stall got=%0d exp=%0d",
               stall_cycles, exp_stall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_divide();
    test_div_mstall();
    test_done_mstall();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
